// File: rtl/dcache_pkg.sv
// Shared types and helpers for the N-way burst data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_REFILL
    } state_t;

    // Core access size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Beat size tied off by the AXI wrapper: 4 bytes per beat
    localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

    // Byte-lane enables for a store of the given size at the given byte offset
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SIZE_BYTE: return 4'b0001 << lsb;
            SIZE_HALF: return 4'b0011 << lsb;
            SIZE_WORD: return 4'hf;
            default:   return 4'hf;
        endcase
    endfunction

    // Replace the enabled byte lanes of old_word with those of new_word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++)
            if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/dcache_way_ram.sv
// One cache way: tag/valid/dirty per set plus a byte-writable data array.
// Reads are asynchronous so the registered request can be looked up in one cycle.
module dcache_way_ram #(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [INDEX_WIDTH-1:0]               index,
    input  logic [OFFSET_WIDTH-3:0]              rd_word,
    output logic [31-INDEX_WIDTH-OFFSET_WIDTH:0] rd_tag,
    output logic                                 rd_valid,
    output logic                                 rd_dirty,
    output logic [31:0]                          rd_data,
    input  logic                                 meta_we,
    input  logic [31-INDEX_WIDTH-OFFSET_WIDTH:0] meta_tag,
    input  logic                                 meta_dirty,
    input  logic [OFFSET_WIDTH-3:0]              wr_word,
    input  logic [3:0]                           data_we,
    input  logic [31:0]                          wdata
);

    localparam int SETS  = 1 << INDEX_WIDTH;
    localparam int BEATS = 1 << (OFFSET_WIDTH - 2);
    localparam int TAG_W = 32 - INDEX_WIDTH - OFFSET_WIDTH;

    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS*BEATS];
    logic [SETS-1:0]  valid_bits;
    logic [SETS-1:0]  dirty_bits;

    // Valid/dirty state: cleared on reset, written when the line is filled or stored to
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (meta_we) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= meta_dirty;
        end
    end

    // Tag and data storage, byte-lane writes
    // NOTE: tag/data arrays are not reset; the valid bits alone mark which lines hold real contents.
    always_ff @(posedge clk) begin
        if (meta_we) tag_mem[index] <= meta_tag;
        for (int b = 0; b < 4; b++)
            if (data_we[b]) data_mem[{index, wr_word}][8*b +: 8] <= wdata[8*b +: 8];
    end

    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid_bits[index];
    assign rd_dirty = dirty_bits[index];
    assign rd_data  = data_mem[{index, rd_word}];

endmodule

// File: rtl/d_cache_nway_burst.sv
// N-way set-associative write-back/write-allocate data cache with AXI burst refill
// and write-back. Optional macro EARLY_RESTART_EN: a load miss completes on the
// handshake of the requested refill beat instead of on rlast.
module d_cache_nway_burst
    import dcache_pkg::*;
#(
    parameter int INDEX_WIDTH  = 7,
    parameter int OFFSET_WIDTH = 5,
    parameter int WAY_NUM      = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_data_req,
    input  logic        cpu_data_wr,
    input  logic [1:0]  cpu_data_size,
    input  logic [31:0] cpu_data_addr,
    input  logic [31:0] cpu_data_wdata,
    output logic [31:0] cpu_data_rdata,
    output logic        cpu_data_addr_ok,
    output logic        cpu_data_data_ok,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    localparam int SETS     = 1 << INDEX_WIDTH;
    localparam int BEAT_NUM = 1 << (OFFSET_WIDTH - 2);
    localparam int WORD_W   = OFFSET_WIDTH - 2;
    localparam int TAG_W    = 32 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WAY_W    = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(BEAT_NUM - 1);
    localparam logic [3:0]        BURST_LEN = 4'(BEAT_NUM - 1);

    state_t            state;
    logic              accept;
    logic              req_wr;
    logic [31:2]       req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_mask;
    logic [WAY_W-1:0]  victim;
    logic [WORD_W-1:0] beat;
    logic [31:0]       refill_word;
    logic [31:0]       rdata_q;
    logic [WAY_W-1:0]  rr_ptr [SETS];

    logic [TAG_W-1:0]       req_tag;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [WORD_W-1:0]      req_word;
    assign req_tag   = req_addr[31 -: TAG_W];
    assign req_index = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign req_word  = req_addr[2 +: WORD_W];

    logic [TAG_W-1:0]   way_tag  [WAY_NUM];
    logic [31:0]        way_data [WAY_NUM];
    logic [WAY_NUM-1:0] way_valid, way_dirty, way_meta_we, hit_vec;
    logic [3:0]         way_data_we [WAY_NUM];
    logic [WORD_W-1:0]  rd_word, wr_word;
    logic [31:0]        ram_wdata, hit_word, beat_wdata, refill_word_now;
    logic [WAY_W-1:0]   victim_next, rr_next;
    logic               hit, hit_ok, r_hs, refill_ok;

    for (genvar g = 0; g < WAY_NUM; g++) begin : g_way
        dcache_way_ram #(.INDEX_WIDTH(INDEX_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH)) u_way (
            .clk(clk), .resetn(resetn), .index(req_index), .rd_word(rd_word),
            .rd_tag(way_tag[g]), .rd_valid(way_valid[g]), .rd_dirty(way_dirty[g]),
            .rd_data(way_data[g]), .meta_we(way_meta_we[g]), .meta_tag(req_tag),
            .meta_dirty(req_wr), .wr_word(wr_word), .data_we(way_data_we[g]),
            .wdata(ram_wdata)
        );
    end

    assign rd_word    = (state == S_WB) ? beat : req_word;
    assign wr_word    = (state == S_REFILL) ? beat : req_word;
    assign r_hs       = (state == S_REFILL) && rvalid && rready;
    assign hit_ok     = (state == S_LOOKUP) && hit;
    assign beat_wdata = (req_wr && beat == req_word) ? merge_bytes(rdata, req_wdata, req_mask) : rdata;
    assign ram_wdata  = (state == S_REFILL) ? beat_wdata : req_wdata;
    assign refill_word_now = (beat == req_word) ? rdata : refill_word;
    assign rr_next    = (WAY_NUM == 1) ? '0 : WAY_W'(rr_ptr[req_index] + 1'b1);

`ifdef EARLY_RESTART_EN
    assign refill_ok = req_wr ? (r_hs && rlast) : (r_hs && beat == req_word);
`else
    assign refill_ok = r_hs && rlast;
`endif

    // Hit detection, hit-word select and victim choice for the latched request
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hit_vec     = '0;
        hit_word    = '0;
        victim_next = rr_ptr[req_index];
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
            if (!way_valid[w]) victim_next = WAY_W'(w);
        end
        for (int w = 0; w < WAY_NUM; w++)
            if (hit_vec[w]) hit_word = hit_word | way_data[w];
        hit = |hit_vec;
    end

    // Per-way write enables: store hit in LOOKUP, refill beats into the victim
    always_comb begin
        for (int w = 0; w < WAY_NUM; w++) begin
            way_meta_we[w] = 1'b0;
            way_data_we[w] = 4'h0;
            if (hit_ok && req_wr && hit_vec[w]) begin
                way_meta_we[w] = 1'b1;
                way_data_we[w] = req_mask;
            end
            if (r_hs && victim == WAY_W'(w)) begin
                way_meta_we[w] = rlast;
                way_data_we[w] = 4'hf;
            end
        end
    end

    assign cpu_data_addr_ok = accept && cpu_data_req;
    assign cpu_data_data_ok = hit_ok || refill_ok;
    assign cpu_data_rdata   = (hit_ok && !req_wr)    ? hit_word :
                              (refill_ok && !req_wr) ? refill_word_now : rdata_q;
    assign wdata = wvalid ? way_data[victim] : '0;
    assign arlen = arvalid ? BURST_LEN : '0;
    assign awlen = awvalid ? BURST_LEN : '0;

    // Cache controller FSM with registered AXI handshake outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            accept      <= 1'b0;
            req_wr      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_mask    <= '0;
            victim      <= '0;
            beat        <= '0;
            refill_word <= '0;
            rdata_q     <= '0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wvalid      <= 1'b0;
            wlast       <= 1'b0;
            bready      <= 1'b0;
            for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
        end else begin
            if (cpu_data_data_ok && !req_wr) rdata_q <= cpu_data_rdata;
            case (state)
                S_IDLE: begin
                    if (cpu_data_addr_ok) begin
                        req_wr    <= cpu_data_wr;
                        req_addr  <= cpu_data_addr[31:2];
                        req_wdata <= cpu_data_wdata;
                        req_mask  <= byte_mask(cpu_data_size, cpu_data_addr[1:0]);
                        accept    <= 1'b0;
                        state     <= S_LOOKUP;
                    end else begin
                        accept <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        accept <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        victim <= victim_next;
                        if (way_valid[victim_next] && way_dirty[victim_next]) begin
                            awaddr  <= {way_tag[victim_next], req_index, OFFSET_WIDTH'(0)};
                            awvalid <= 1'b1;
                            bready  <= 1'b1;
                            beat    <= '0;
                            state   <= S_WB;
                        end else begin
                            araddr  <= {req_addr[31:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
                            arvalid <= 1'b1;
                            state   <= S_REFILL;
                        end
                    end
                end
                S_WB: begin
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wlast   <= 1'b0;
                        beat    <= '0;
                    end
                    if (wvalid && wready) begin
                        if (beat == LAST_BEAT) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                        end else begin
                            beat  <= WORD_W'(beat + 1'b1);
                            wlast <= (WORD_W'(beat + 1'b1) == LAST_BEAT);
                        end
                    end
                    if (bvalid && bready) begin
                        bready  <= 1'b0;
                        araddr  <= {req_addr[31:OFFSET_WIDTH], OFFSET_WIDTH'(0)};
                        arvalid <= 1'b1;
                        state   <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        beat    <= '0;
                    end
                    if (r_hs) begin
                        beat <= WORD_W'(beat + 1'b1);
                        if (beat == req_word) refill_word <= rdata;
                        if (rlast) begin
                            rready            <= 1'b0;
                            rr_ptr[req_index] <= rr_next;
                            accept            <= 1'b1;
                            state             <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
